tdd_frame_sched: RTL and testbench
==================================

Name: tdd_frame_sched

Overview:
- Frame timer and TDD scheduler for the sample-stream DMA bridge.
- Runs in the sample-clock domain and drives the bridge's receive-capture enable (ien) and transmit-output enable (oen).
- Timing comes from per-frame windows programmed through the register space: frame length, one-shot frame adjust, TX/RX start/end.
- Publishes frame counters and an adjust-pending flag for software readback.

Parameters:
- CNT_W, 24, width of frame length, in-frame counter, window and adjust fields.
- FNUM_W, 32, width of the free-running frame number.

Ports:
- clk  in  1  sample clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  scheduler run enable (register space).
- wait_sync  in  1  1: start only on sync pulse; 0: start immediately.
- sync  in  1  single-cycle external frame-boundary pulse.
- tddmode  in  1  1: TDD window gating; 0: FDD, both enables held high while running.
- frame_len  in  CNT_W  frame length in clk cycles (values below 2 are treated as 2).
- frame_adj  in  CNT_W  signed one-shot adjustment to one frame's length.
- adj_req  in  1  single-cycle pulse that latches frame_adj.
- tstart, tend  in  CNT_W  TX window.
- rstart, rend  in  CNT_W  RX window.
- ien  out  1  RX capture enable to the DMA bridge.
- oen  out  1  TX output enable to the DMA bridge.
- frame_start  out  1  one-cycle pulse when the counter is 0.
- frame_cnt  out  CNT_W  in-frame counter.
- frame_num  out  FNUM_W  frames started since leaving IDLE.
- adj_pending  out  1  adjustment latched but not yet applied.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset state:
  - Outputs: ien=0, oen=0, frame_start=0, frame_cnt=0, frame_num=0, adj_pending=0.
  - Internals: state=IDLE, shadow registers=0.
  - Reset applied mid-frame abandons the frame immediately; no partial windows are emitted afterwards.
- States: IDLE, ARMED, RUN.
  - IDLE -> ARMED when en=1.
  - ARMED -> RUN on the next cycle if wait_sync=0; otherwise on the cycle sync=1.
  - Any state -> IDLE when en=0. IDLE clears frame_cnt, frame_num and both enables on the next edge; adj_pending is kept.
- Frame boundary: entering RUN, counter wrap, or sync=1 in RUN. At a boundary:
  - frame_cnt<=0 and frame_num increments. The first frame after ARMED gives frame_num=1.
  - Shadow registers load frame_len, tstart, tend, rstart, rend and tddmode. Mid-frame edits to these inputs have no effect until the next boundary.
  - Effective length L = max(2, frame_len + frame_adj_latched) if adj_pending, else max(2, frame_len). The sum is computed at CNT_W+1 bits, signed; a negative result clamps to 2.
  - adj_pending clears.
- Counting: in RUN, frame_cnt increments each cycle and wraps after reaching L-1. A sync in mid-frame truncates the frame and is treated as a boundary.
- Adjust handshake:
  - adj_req latches frame_adj and sets adj_pending.
  - A second adj_req while pending overwrites the value; pending stays 1.
  - adj_req in the same cycle as a boundary: the boundary consumes the previously pending value (if any). The new value becomes pending for the following boundary.
- Windows, using shadow values:
  - in_win(s,e) = (s<e) ? (s<=cnt<e) : (s>e) ? (cnt>=s || cnt<e) : 0. s>e gives a wrapped window; s==e gives an empty window.
  - Window positions >= L are never reached.
- Enables:
  - ien and oen are registered with 1-cycle latency: the value at edge t+1 reflects frame_cnt at edge t.
  - tddmode=1: oen=in_win(tstart,tend), ien=in_win(rstart,rend). Both may be high together; no mutual exclusion is enforced.
  - tddmode=0: ien=oen=1 throughout RUN.
  - Outside RUN: ien=oen=0.
- frame_start is registered and asserted for the one cycle frame_cnt==0 in RUN.

Decomposition:
- Shared package tdd_sched_pkg:
  - state encoding (IDLE/ARMED/RUN);
  - MIN_FRAME_LEN=2;
  - window-compare function in_win.
- One sub-module, tdd_win_cmp: combinational window compare, instantiated twice (TX and RX).
- The FSM, counter, shadow registers and adjust logic stay in the top module.

Test Plan:
- FDD basic:
  - Stimulus: frame_len=10, tddmode=0, wait_sync=0, en 0->1.
  - Response: RUN two cycles after en; ien=oen=1 from then on; frame_start every 10 cycles; frame_num counts 1,2,3.
- TDD windows:
  - Stimulus: frame_len=100, rstart=0, rend=40, tstart=50, tend=90.
  - Response: ien high for frame_cnt 0..39 and oen high for 50..89, each one cycle late; both low for 40..49 and 90..99.
- Wrapped and empty windows:
  - Stimulus: tstart=90, tend=10; rstart=rend=30; frame_len=100.
  - Response: oen high for cnt 90..99 and 0..9; ien never high.
- Adjust:
  - Stimulus: adj_req with frame_adj=+5 mid-frame, then with -3; separately frame_adj=-200.
  - Response: the next frame is 105 cycles and the following frame 97; adj_pending is 1 until each boundary. frame_adj=-200 clamps the frame to 2 cycles.
- Adjust at boundary:
  - Stimulus: adj_req in the same cycle as a wrap with +5 already pending, carrying a new value of +7.
  - Response: +5 is applied now and +7 at the next boundary; adj_pending stays 1 throughout.
- Sync and reset:
  - Stimulus: wait_sync=1 with no sync for 50 cycles, then sync; later sync at cnt=37; later rst at cnt=20; mid-frame frame_len change.
  - Response: stays ARMED until sync, then runs. Sync at cnt=37 restarts the counter at 0 and increments frame_num. rst at cnt=20 zeroes all outputs on the next edge. A mid-frame frame_len change takes effect only at the next boundary.

Source files
------------

// File: rtl/tdd_sched_pkg.sv
// Shared types and helpers for the TDD frame scheduler.
// Holds the state encoding, the minimum frame length and the window test.
package tdd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } sched_state_t;

    localparam int MIN_FRAME_LEN = 2;
    localparam int WIN_W         = 32;

    // start > end describes a window that wraps through the frame boundary
    function automatic logic in_win(input logic [WIN_W-1:0] s,
                                    input logic [WIN_W-1:0] e,
                                    input logic [WIN_W-1:0] cnt);
        if (s < e)
            return (cnt >= s) && (cnt < e);
        else if (s > e)
            return (cnt >= s) || (cnt < e);
        else
            return 1'b0;
    endfunction

endpackage

// File: rtl/tdd_win_cmp.sv
// Combinational in-frame window compare, one instance per TX/RX window.
module tdd_win_cmp
    import tdd_sched_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0] i_start,
    input  logic [W-1:0] i_end,
    input  logic [W-1:0] i_cnt,
    output logic         o_hit
);

    assign o_hit = in_win(WIN_W'(i_start), WIN_W'(i_end), WIN_W'(i_cnt));

endmodule

// File: rtl/tdd_frame_sched.sv
// Frame timer and TDD scheduler: IDLE/ARMED/RUN control, in-frame counter,
// boundary-latched shadow timing, one-shot length adjust and registered enables.
//
// state | meaning
// IDLE  | stopped, counters and enables cleared
// ARMED | waiting for start (immediate or on sync)
// RUN   | counting frames, driving ien/oen
module tdd_frame_sched
    import tdd_sched_pkg::*;
#(
    parameter int CNT_W  = 24,
    parameter int FNUM_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              wait_sync,
    input  logic              sync,
    input  logic              tddmode,
    input  logic [CNT_W-1:0]  frame_len,
    input  logic [CNT_W-1:0]  frame_adj,
    input  logic              adj_req,
    input  logic [CNT_W-1:0]  tstart,
    input  logic [CNT_W-1:0]  tend,
    input  logic [CNT_W-1:0]  rstart,
    input  logic [CNT_W-1:0]  rend,
    output logic              ien,
    output logic              oen,
    output logic              frame_start,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [FNUM_W-1:0] frame_num,
    output logic              adj_pending
);

    sched_state_t r_state, w_state_nxt;

    logic [CNT_W-1:0]  r_cnt, r_len, r_ts, r_te, r_rs, r_re, r_adj;
    logic [FNUM_W-1:0] r_num;
    logic              r_tdd, r_pend, r_ien, r_oen, r_fs;

    logic              w_boundary, w_wrap, w_tx_hit, w_rx_hit;
    logic signed [CNT_W:0] w_sum, w_base;
    logic [CNT_W-1:0]  w_len_eff;

    // Adjusted length is formed one bit wider and signed so a large negative
    // adjust clamps to the minimum instead of wrapping to a huge frame.
    assign w_sum     = $signed({1'b0, frame_len}) + $signed({r_adj[CNT_W-1], r_adj});
    assign w_base    = r_pend ? w_sum : $signed({1'b0, frame_len});
    assign w_len_eff = (w_base < $signed((CNT_W+1)'(MIN_FRAME_LEN)))
                       ? CNT_W'(MIN_FRAME_LEN) : w_base[CNT_W-1:0];

    assign w_wrap = (r_cnt == r_len - CNT_W'(1));

    tdd_win_cmp #(.W(CNT_W)) u_tx_win (
        .i_start (r_ts),
        .i_end   (r_te),
        .i_cnt   (r_cnt),
        .o_hit   (w_tx_hit)
    );

    tdd_win_cmp #(.W(CNT_W)) u_rx_win (
        .i_start (r_rs),
        .i_end   (r_re),
        .i_cnt   (r_cnt),
        .o_hit   (w_rx_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_boundary  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!wait_sync || sync) begin
                    w_state_nxt = ST_RUN;
                    w_boundary  = 1'b1;
                end
            end
            ST_RUN: begin
                if (w_wrap || sync) w_boundary = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!en) begin
            w_state_nxt = ST_IDLE;
            w_boundary  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_num  <= '0;
            r_len  <= '0;
            r_ts   <= '0;
            r_te   <= '0;
            r_rs   <= '0;
            r_re   <= '0;
            r_tdd  <= 1'b0;
            r_adj  <= '0;
            r_pend <= 1'b0;
            r_ien  <= 1'b0;
            r_oen  <= 1'b0;
            r_fs   <= 1'b0;
        end else begin
            // A request coinciding with a boundary survives it: the boundary
            // consumes the old value, the new one waits for the next frame.
            if (adj_req) begin
                r_adj  <= frame_adj;
                r_pend <= 1'b1;
            end else if (w_boundary) begin
                r_pend <= 1'b0;
            end

            if (!en) begin
                r_cnt <= '0;
                r_num <= '0;
                r_fs  <= 1'b0;
            end else if (w_boundary) begin
                r_cnt <= '0;
                r_num <= r_num + FNUM_W'(1);
                r_fs  <= 1'b1;
                r_len <= w_len_eff;
                r_ts  <= tstart;
                r_te  <= tend;
                r_rs  <= rstart;
                r_re  <= rend;
                r_tdd <= tddmode;
            end else begin
                if (r_state == ST_RUN) r_cnt <= r_cnt + CNT_W'(1);
                r_fs <= 1'b0;
            end

            if (en && r_state == ST_RUN) begin
                r_ien <= r_tdd ? w_rx_hit : 1'b1;
                r_oen <= r_tdd ? w_tx_hit : 1'b1;
            end else begin
                r_ien <= 1'b0;
                r_oen <= 1'b0;
            end
        end
    end

    assign ien         = r_ien;
    assign oen         = r_oen;
    assign frame_start = r_fs;
    assign frame_cnt   = r_cnt;
    assign frame_num   = r_num;
    assign adj_pending = r_pend;

endmodule

// File: tb/tb_tdd_frame_sched.sv
// Self-checking bench for tdd_frame_sched: directed scenarios plus random
// traffic, compared each cycle against a frame-level reference model.
module tb_tdd_frame_sched;

    localparam int CNT_W  = 24;
    localparam int FNUM_W = 32;

    logic              clk = 1'b0;
    logic              rst, en, wait_sync, sync, tddmode, adj_req;
    logic [CNT_W-1:0]  frame_len, frame_adj, tstart, tend, rstart, rend;
    logic              ien, oen, frame_start, adj_pending;
    logic [CNT_W-1:0]  frame_cnt;
    logic [FNUM_W-1:0] frame_num;

    int n_total = 0;
    int n_bad   = 0;

    // reference model: mode 0 stopped, 1 waiting to start, 2 running
    int m_mode, m_cnt, m_num, m_len, m_adj;
    bit m_pend, m_ien, m_oen, m_fs, m_tdd;
    int m_ts, m_te, m_rs, m_re;

    always #5 clk = ~clk;

    tdd_frame_sched #(.CNT_W(CNT_W), .FNUM_W(FNUM_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .wait_sync   (wait_sync),
        .sync        (sync),
        .tddmode     (tddmode),
        .frame_len   (frame_len),
        .frame_adj   (frame_adj),
        .adj_req     (adj_req),
        .tstart      (tstart),
        .tend        (tend),
        .rstart      (rstart),
        .rend        (rend),
        .ien         (ien),
        .oen         (oen),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .frame_num   (frame_num),
        .adj_pending (adj_pending)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string tag);
        n_total++;
        n_bad++;
        $display("FAIL %s: timeout at %0t", tag, $time);
    endtask

    function automatic bit win(input int s, input int e, input int c);
        if (s < e)      return (c >= s) && (c < e);
        else if (s > e) return (c >= s) || (c < e);
        else            return 1'b0;
    endfunction

    task automatic model_step();
        bit bnd, running, nien, noen;
        int sum;
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_num = 0; m_len = 0; m_adj = 0;
            m_pend = 0; m_ien = 0; m_oen = 0; m_fs = 0; m_tdd = 0;
            m_ts = 0; m_te = 0; m_rs = 0; m_re = 0;
            return;
        end
        running = (m_mode == 2);
        bnd = en && ((m_mode == 1 && (!wait_sync || sync)) ||
                     (running && (m_cnt == m_len - 1 || sync)));
        nien = (en && running) ? (m_tdd ? win(m_rs, m_re, m_cnt) : 1'b1) : 1'b0;
        noen = (en && running) ? (m_tdd ? win(m_ts, m_te, m_cnt) : 1'b1) : 1'b0;
        sum = int'(frame_len) + (m_pend ? m_adj : 0);
        if (!en) begin
            m_mode = 0; m_cnt = 0; m_num = 0; m_fs = 0;
        end else if (bnd) begin
            m_mode = 2; m_cnt = 0; m_num++; m_fs = 1;
            m_len = (sum < 2) ? 2 : sum;
            m_ts = int'(tstart); m_te = int'(tend);
            m_rs = int'(rstart); m_re = int'(rend);
            m_tdd = tddmode;
        end else begin
            if (m_mode == 0) m_mode = 1;
            if (running) m_cnt++;
            m_fs = 0;
        end
        if (adj_req) begin
            m_adj  = int'($signed(frame_adj));
            m_pend = 1;
        end else if (bnd) begin
            m_pend = 0;
        end
        m_ien = nien;
        m_oen = noen;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("ien", {31'd0, ien}, {31'd0, m_ien});
        check("oen", {31'd0, oen}, {31'd0, m_oen});
        check("frame_start", {31'd0, frame_start}, {31'd0, m_fs});
        check("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        check("frame_num", frame_num, 32'(m_num));
        check("adj_pending", {31'd0, adj_pending}, {31'd0, m_pend});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame_gap(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 1000);
        if (n >= 1000) fail_timeout("frame_gap");
    endtask

    task automatic wait_cnt(input int c);
        int k = 0;
        while (m_cnt != c && k < 2000) begin
            tick();
            k++;
        end
        if (k >= 2000) fail_timeout("wait_cnt");
    endtask

    task automatic pulse_adj(input int a);
        adj_req   = 1'b1;
        frame_adj = CNT_W'(a);
        tick();
        adj_req   = 1'b0;
    endtask

    task automatic restart(input int len, input bit tdd, input bit ws);
        en = 1'b0;
        tick();
        frame_len = CNT_W'(len);
        tddmode   = tdd;
        wait_sync = ws;
        en        = 1'b1;
    endtask

    initial begin
        int g, n, num_before;
        rst = 1'b1; en = 1'b0; wait_sync = 1'b0; sync = 1'b0; tddmode = 1'b0;
        adj_req = 1'b0; frame_len = '0; frame_adj = '0;
        tstart = '0; tend = '0; rstart = '0; rend = '0;
        ticks(3);
        check("reset_num", frame_num, 32'd0);
        rst = 1'b0;

        // FDD basic
        restart(10, 1'b0, 1'b0);
        ticks(2);
        check("fdd_first_fs", {31'd0, frame_start}, 32'd1);
        check("fdd_first_num", frame_num, 32'd1);
        frame_gap(n);
        check("fdd_len", n, 10);
        ticks(25);

        // TDD windows
        rstart = 0; rend = 40; tstart = 50; tend = 90;
        restart(100, 1'b1, 1'b0);
        ticks(210);

        // wrapped TX window, empty RX window
        tstart = 90; tend = 10; rstart = 30; rend = 30;
        restart(100, 1'b1, 1'b0);
        ticks(210);

        // adjust +5, -3, then clamp
        restart(100, 1'b0, 1'b0);
        tick();
        wait_cnt(50);
        pulse_adj(5);
        check("adj_pend_set", {31'd0, adj_pending}, 32'd1);
        frame_gap(n);
        ticks(10);
        pulse_adj(-3);
        frame_gap(n);
        check("adj_p5_len", 11 + n, 105);
        frame_gap(n);
        check("adj_m3_len", n, 97);
        pulse_adj(-200);
        frame_gap(n);
        frame_gap(n);
        check("adj_clamp_len", n, 2);
        frame_gap(n);
        check("adj_after_len", n, 100);

        // adjust arriving on the wrap edge
        ticks(3);
        pulse_adj(5);
        wait_cnt(m_len - 1);
        pulse_adj(7);
        check("badj_pend", {31'd0, adj_pending}, 32'd1);
        frame_gap(n);
        check("badj_len5", n, 105);
        frame_gap(n);
        check("badj_len7", n, 107);

        // wait for sync, mid-frame sync, mid-frame length edit, reset
        restart(60, 1'b0, 1'b1);
        ticks(50);
        check("ws_hold_num", frame_num, 32'd0);
        check("ws_hold_oen", {31'd0, oen}, 32'd0);
        sync = 1'b1; tick(); sync = 1'b0;
        check("ws_go_fs", {31'd0, frame_start}, 32'd1);
        wait_cnt(37);
        num_before = m_num;
        sync = 1'b1; tick(); sync = 1'b0;
        check("sync_cnt", 32'(frame_cnt), 32'd0);
        check("sync_num", frame_num, 32'(num_before + 1));
        wait_cnt(5);
        frame_len = CNT_W'(30);
        frame_gap(n);
        check("midchg_old_len", 6 + n - 1, 60);
        frame_gap(n);
        check("midchg_new_len", n, 30);
        wait_cnt(20);
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_cnt", 32'(frame_cnt), 32'd0);
        check("rst_ien", {31'd0, ien}, 32'd0);
        check("rst_num", frame_num, 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst     = ($urandom_range(499) == 0);
            if ($urandom_range(199) == 0) en = ~en;
            else if (!en && $urandom_range(9) == 0) en = 1'b1;
            if (!en) wait_sync = $urandom_range(1);
            sync    = ($urandom_range(59) == 0);
            adj_req = ($urandom_range(39) == 0);
            frame_adj = ($urandom_range(9) == 0) ? CNT_W'(-200)
                        : CNT_W'(int'($urandom_range(40)) - 20);
            if ($urandom_range(29) == 0) frame_len = CNT_W'($urandom_range(40));
            if ($urandom_range(29) == 0) begin
                tstart  = CNT_W'($urandom_range(45));
                tend    = CNT_W'($urandom_range(45));
                rstart  = CNT_W'($urandom_range(45));
                rend    = CNT_W'($urandom_range(45));
                tddmode = $urandom_range(1);
            end
            tick();
        end
        rst = 1'b0; sync = 1'b0; adj_req = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
